// File: rtl/map_phase_sched.sv
// map_phase_sched: frame-level sequencer for the MAP decoder datapath.
// A start pulse in IDLE runs four phases of FRAME_LEN steps each
// (GAMMA write, ALPHA forward, BETA backward, LLR output), then a
// one-cycle DONE, then back to IDLE.
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   start                 frame request, honoured only in IDLE
//   stall                 datapath hold; freezes step counter and phase
//   busy, done, phase     handshake / status (phase: IDLE=0 .. DONE=5)
//   gm_we/gm_addr         gamma memory control
//   am_we/am_addr         alpha memory control
//   bm_we/bm_addr         beta memory control
//   llr_valid, llr_idx    LLR output qualifier and trellis step index
module map_phase_sched #(
  parameter int FRAME_LEN = 8,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [2:0]        phase,
  output logic              gm_we,
  output logic [ADDR_W-1:0] gm_addr,
  output logic              am_we,
  output logic [ADDR_W-1:0] am_addr,
  output logic              bm_we,
  output logic [ADDR_W-1:0] bm_addr,
  output logic              llr_valid,
  output logic [ADDR_W-1:0] llr_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GAMMA = 3'd1;
  localparam logic [2:0] S_ALPHA = 3'd2;
  localparam logic [2:0] S_BETA  = 3'd3;
  localparam logic [2:0] S_LLR   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

  logic [2:0]        phase_q, phase_n;
  logic [ADDR_W-1:0] k_q, k_n;

  logic              busy_n, done_n;
  logic              gm_we_n, am_we_n, bm_we_n, llr_valid_n;
  logic              gm_we_q, am_we_q, bm_we_q, llr_valid_q;
  logic [ADDR_W-1:0] gm_addr_n, am_addr_n, bm_addr_n, llr_idx_n;
  logic [ADDR_W-1:0] rev_n;

  // Next step: advance unless stalled in an active phase.
  always_comb begin
    phase_n = phase_q;
    k_n     = k_q;
    case (phase_q)
      S_IDLE: begin
        if (start) begin
          phase_n = S_GAMMA;
          k_n     = '0;
        end
      end
      S_GAMMA, S_ALPHA, S_BETA, S_LLR: begin
        if (!stall) begin
          if (k_q == LAST) begin
            phase_n = phase_q + 3'd1;
            k_n     = '0;
          end else begin
            k_n = k_q + ADDR_W'(1);
          end
        end
      end
      default: phase_n = S_IDLE;
    endcase
  end

  // Output values for the step about to be presented, so every output
  // leaves a flop; a held step recomputes identical addresses.
  always_comb begin
    rev_n       = LAST - k_n;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    gm_we_n     = 1'b0;
    am_we_n     = 1'b0;
    bm_we_n     = 1'b0;
    llr_valid_n = 1'b0;
    gm_addr_n   = '0;
    am_addr_n   = '0;
    bm_addr_n   = '0;
    llr_idx_n   = '0;
    case (phase_n)
      S_GAMMA: begin
        busy_n    = 1'b1;
        gm_we_n   = 1'b1;
        gm_addr_n = k_n;
      end
      S_ALPHA: begin
        busy_n    = 1'b1;
        gm_addr_n = k_n;
        am_we_n   = 1'b1;
        am_addr_n = k_n;
      end
      S_BETA: begin
        busy_n    = 1'b1;
        gm_addr_n = rev_n;
        bm_we_n   = 1'b1;
        bm_addr_n = rev_n;
      end
      S_LLR: begin
        busy_n      = 1'b1;
        gm_addr_n   = k_n;
        am_addr_n   = k_n;
        bm_addr_n   = k_n;
        llr_valid_n = 1'b1;
        llr_idx_n   = k_n;
      end
      S_DONE:  done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= S_IDLE;
      k_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      gm_we_q     <= 1'b0;
      am_we_q     <= 1'b0;
      bm_we_q     <= 1'b0;
      llr_valid_q <= 1'b0;
      gm_addr     <= '0;
      am_addr     <= '0;
      bm_addr     <= '0;
      llr_idx     <= '0;
    end else begin
      phase_q     <= phase_n;
      k_q         <= k_n;
      busy        <= busy_n;
      done        <= done_n;
      gm_we_q     <= gm_we_n;
      am_we_q     <= am_we_n;
      bm_we_q     <= bm_we_n;
      llr_valid_q <= llr_valid_n;
      gm_addr     <= gm_addr_n;
      am_addr     <= am_addr_n;
      bm_addr     <= bm_addr_n;
      llr_idx     <= llr_idx_n;
    end
  end

  assign phase = phase_q;

  // Enables are suppressed in the very cycle stall is high, so the held
  // step is issued once, when stall drops. Enables are zero outside the
  // active phases, so stall cannot affect IDLE or DONE.
  assign gm_we     = gm_we_q     & ~stall;
  assign am_we     = am_we_q     & ~stall;
  assign bm_we     = bm_we_q     & ~stall;
  assign llr_valid = llr_valid_q & ~stall;

endmodule

// File: tb/tb_map_phase_sched.sv
// Testbench for map_phase_sched: expected per-cycle output vectors are
// queued from the phase/step description, then popped and compared one
// per cycle while the matching stimulus is driven.
module tb_map_phase_sched;

  localparam int AW = 8;
  localparam int N8 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic start8 = 1'b0;
  logic start1 = 1'b0;

  logic          busy8, done8, gm_we8, am_we8, bm_we8, llr_valid8;
  logic [2:0]    phase8;
  logic [AW-1:0] gm_addr8, am_addr8, bm_addr8, llr_idx8;
  logic          busy1, done1, gm_we1, am_we1, bm_we1, llr_valid1;
  logic [2:0]    phase1;
  logic [AW-1:0] gm_addr1, am_addr1, bm_addr1, llr_idx1;

  always #5 clk = ~clk;

  map_phase_sched #(.FRAME_LEN(N8), .ADDR_W(AW)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .stall(stall),
    .busy(busy8), .done(done8), .phase(phase8),
    .gm_we(gm_we8), .gm_addr(gm_addr8),
    .am_we(am_we8), .am_addr(am_addr8),
    .bm_we(bm_we8), .bm_addr(bm_addr8),
    .llr_valid(llr_valid8), .llr_idx(llr_idx8)
  );

  map_phase_sched #(.FRAME_LEN(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stall(stall),
    .busy(busy1), .done(done1), .phase(phase1),
    .gm_we(gm_we1), .gm_addr(gm_addr1),
    .am_we(am_we1), .am_addr(am_addr1),
    .bm_we(bm_we1), .bm_addr(bm_addr1),
    .llr_valid(llr_valid1), .llr_idx(llr_idx1)
  );

  typedef struct packed {
    logic [2:0]    phase;
    logic          busy;
    logic          done;
    logic          gm_we;
    logic [AW-1:0] gm_addr;
    logic          am_we;
    logic [AW-1:0] am_addr;
    logic          bm_we;
    logic [AW-1:0] bm_addr;
    logic          llr_valid;
    logic [AW-1:0] llr_idx;
  } vec_t;

  vec_t q[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t observe(input bit sel);
    vec_t v;
    if (sel) v = '{phase1, busy1, done1, gm_we1, gm_addr1, am_we1, am_addr1,
                   bm_we1, bm_addr1, llr_valid1, llr_idx1};
    else     v = '{phase8, busy8, done8, gm_we8, gm_addr8, am_we8, am_addr8,
                   bm_we8, bm_addr8, llr_valid8, llr_idx8};
    return v;
  endfunction

  task automatic push_idle();
    vec_t v;
    v = '0;
    q.push_back(v);
  endtask

  // Expected vector of phase p at step k of an n-step frame.
  task automatic push_step(input int n, input int p, input int k, input bit en);
    vec_t v;
    v = '0;
    v.phase = 3'(p);
    v.busy  = 1'b1;
    case (p)
      1: begin v.gm_we = en; v.gm_addr = AW'(k); end
      2: begin v.gm_addr = AW'(k); v.am_we = en; v.am_addr = AW'(k); end
      3: begin v.gm_addr = AW'(n-1-k); v.bm_we = en; v.bm_addr = AW'(n-1-k); end
      default: begin
        v.gm_addr = AW'(k); v.am_addr = AW'(k); v.bm_addr = AW'(k);
        v.llr_valid = en; v.llr_idx = AW'(k);
      end
    endcase
    q.push_back(v);
  endtask

  // Full frame plus trailing IDLE; slen held cycles inserted before (sph,sk).
  task automatic push_frame(input int n, input int sph, input int sk, input int slen);
    vec_t v;
    for (int p = 1; p <= 4; p++)
      for (int k = 0; k < n; k++) begin
        if (p == sph && k == sk)
          for (int s = 0; s < slen; s++) push_step(n, p, k, 1'b0);
        push_step(n, p, k, 1'b1);
      end
    v = '0;
    v.phase = 3'd5;
    v.done  = 1'b1;
    q.push_back(v);
    push_idle();
  endtask

  task automatic set_start(input bit sel, input logic val);
    if (sel) start1 = val;
    else     start8 = val;
  endtask

  // Pops one expected vector per cycle. Stall is high on cycles
  // [stall_lo, stall_hi); hold keeps start high; inject pulses start
  // during GAMMA, LLR and DONE.
  task automatic drive_and_check(input string name, input bit sel,
                                 input int stall_lo, input int stall_hi,
                                 input bit hold, input bit inject);
    int total;
    int last;
    vec_t got, want;
    total = q.size();
    last  = total - 1;
    @(posedge clk); #1;
    set_start(sel, 1'b1);
    for (int i = 0; i < total; i++) begin
      @(posedge clk); #1;
      if (hold) set_start(sel, i != last);
      else      set_start(sel, inject && (i == 2 || i == last - 3 || i == last - 1));
      stall = (i >= stall_lo && i < stall_hi);
      @(negedge clk);
      want = q.pop_front();
      got  = observe(sel);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s cycle %0d: got phase=%0d vec=%h, want phase=%0d vec=%h",
                 name, i, got.phase, got, want.phase, want);
      end
    end
    stall = 1'b0;
    set_start(sel, 1'b0);
  endtask

  task automatic check_idle(input string name, input bit sel, input int cycles);
    vec_t got, want;
    for (int i = 0; i < cycles; i++) push_idle();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      want = q.pop_front();
      got  = observe(sel);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s cycle %0d: got vec=%h, want vec=%h", name, i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset8", 1'b0, 2);
    check_idle("reset1", 1'b1, 1);
  endtask

  task automatic test_frame();
    push_frame(N8, 0, 0, 0);
    drive_and_check("frame", 1'b0, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    int at;
    at = N8 + 4;  // ALPHA step 4
    push_frame(N8, 2, 4, 3);
    drive_and_check("stall", 1'b0, at, at + 3, 1'b0, 1'b0);
    // Stall during IDLE must not block or disturb anything.
    stall = 1'b1;
    check_idle("stall_idle", 1'b0, 2);
    stall = 1'b0;
  endtask

  task automatic test_back_to_back();
    push_frame(N8, 0, 0, 0);
    push_frame(N8, 0, 0, 0);
    drive_and_check("b2b", 1'b0, -1, -1, 1'b1, 1'b0);
    check_idle("b2b_after", 1'b0, 2);
  endtask

  task automatic test_reset_mid();
    vec_t got, want;
    int cut;
    cut = 2 * N8 + 2;  // BETA step 2
    push_frame(N8, 0, 0, 0);
    @(posedge clk); #1 start8 = 1'b1;
    for (int i = 0; i <= cut; i++) begin
      @(posedge clk); #1 start8 = 1'b0;
      @(negedge clk);
      want = q.pop_front();
      got  = observe(1'b0);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rstmid cycle %0d: got vec=%h, want vec=%h", i, got, want);
      end
    end
    q.delete();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_idle("rstmid_abort", 1'b0, 4);
    push_frame(N8, 0, 0, 0);
    drive_and_check("rstmid_rerun", 1'b0, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_len1();
    push_frame(1, 0, 0, 0);
    drive_and_check("len1", 1'b1, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_start_inject();
    push_frame(N8, 0, 0, 0);
    drive_and_check("inject", 1'b0, -1, -1, 1'b0, 1'b1);
    check_idle("inject_after", 1'b0, 3);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_len1();
    test_start_inject();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
